// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the NN layer sequencer: FSM state encoding,
// default phase latencies and extraction of per-layer neuron counts.
package nn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_ACT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int unsigned MAC_LAT_DEF = 10;
  localparam int unsigned AF_LAT_DEF  = 30;

  // Widest packed layer-size vector the helper accepts (MAX_LAYERS*NW).
  localparam int unsigned SIZE_VEC_W = 512;

  function automatic logic [SIZE_VEC_W-1:0] layer_size(
    input logic [SIZE_VEC_W-1:0] vec,
    input int unsigned           k,
    input int unsigned           nw
  );
    return (vec >> (k * nw)) & ~({SIZE_VEC_W{1'b1}} << nw);
  endfunction

endpackage

// File: rtl/nn_phase_counter.sv
// Loadable down-counter shared by the LOAD/MAC/ACT phases; saturates at zero,
// freezes while hold_i is high and flags the final count of a phase.
module nn_phase_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          hold_i,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!hold_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Master sequencer for the CORDIC NN datapath: walks layers and neurons,
// driving load/MAC/activation/write strobes with stall, abort and config check.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned NW         = 6,
  parameter int unsigned LW         = $clog2(MAX_LAYERS) + 1,
  parameter int unsigned MAC_LAT    = MAC_LAT_DEF,
  parameter int unsigned AF_LAT     = AF_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     stall,
  input  logic [LW-1:0]            no_layers,
  input  logic [NW-1:0]            n_inputs,
  input  logic [MAX_LAYERS*NW-1:0] layer_sizes,
  input  logic [MAX_LAYERS-1:0]    af_mask,
  output logic                     weight_en,
  output logic                     bias_en,
  output logic                     compute_en,
  output logic                     af_en,
  output logic                     output_wr_en,
  output logic                     output_shft_en,
  output logic                     output_sel,
  output logic                     bias_sel,
  output logic [LW-1:0]            layer_idx,
  output logic [NW-1:0]            neuron_idx,
  output logic [NW-1:0]            input_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned IW   = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int unsigned CW_M = ($clog2(MAC_LAT + 1) > NW) ? $clog2(MAC_LAT + 1) : NW;
  localparam int unsigned CW   = ($clog2(AF_LAT + 1) > CW_M) ? $clog2(AF_LAT + 1) : CW_M;

  state_e                state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d, nlay_q, nlay_d;
  logic [NW-1:0]         neuron_q, neuron_d, input_q, input_d, nin_q, nin_d;
  logic [NW-1:0]         sz_q [MAX_LAYERS];
  logic [NW-1:0]         sz_d [MAX_LAYERS];
  logic [NW-1:0]         sz_cfg [MAX_LAYERS];
  logic [MAX_LAYERS-1:0] mask_q, mask_d;

  logic          cnt_load, cnt_last, frz, cfg_ok, cfg_err;
  logic [CW-1:0] cnt_val;
  logic [NW-1:0] cur_size, cur_fanin;
  logic          last_neuron, last_layer, cur_skip;

  logic ld_q, ld_d, cmp_q, cmp_d, af_q, af_d, wr_q, wr_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, osel_q, osel_d, bsel_q, bsel_d;

  nn_phase_counter #(
    .CW (CW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .hold_i     (frz),
    .last_o     (cnt_last)
  );

  // Configuration legality and size unpacking, evaluated on the live inputs.
  always_comb begin
    cfg_ok = (no_layers != '0) && (no_layers <= LW'(MAX_LAYERS)) && (n_inputs != '0);
    for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
      sz_cfg[k] = NW'(layer_size(SIZE_VEC_W'(layer_sizes), k, NW));
      if ((LW'(k) < no_layers) && (sz_cfg[k] == '0)) begin
        cfg_ok = 1'b0;
      end
    end
  end

  assign cur_size    = sz_q[layer_q[IW-1:0]];
  assign cur_fanin   = (layer_q == '0) ? nin_q : sz_q[layer_q[IW-1:0] - IW'(1)];
  assign cur_skip    = mask_q[layer_q[IW-1:0]];
  assign last_neuron = (neuron_q == cur_size - NW'(1));
  assign last_layer  = (layer_q == nlay_q - LW'(1));

  assign frz = stall && !abort &&
               (state_q inside {S_LOAD, S_MAC, S_ACT, S_WRITE});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
      input_q  <= '0;
      nlay_q   <= '0;
      nin_q    <= '0;
      mask_q   <= '0;
      for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
        sz_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      input_q  <= input_d;
      nlay_q   <= nlay_d;
      nin_q    <= nin_d;
      mask_q   <= mask_d;
      sz_q     <= sz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    input_d  = input_q;
    nlay_d   = nlay_q;
    nin_d    = nin_q;
    mask_d   = mask_q;
    sz_d     = sz_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cfg_err  = 1'b0;

    if (abort) begin
      state_d  = S_IDLE;
      layer_d  = '0;
      neuron_d = '0;
      input_d  = '0;
    end else if (!frz) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_d  = S_LOAD;
              layer_d  = '0;
              neuron_d = '0;
              input_d  = '0;
              nlay_d   = no_layers;
              nin_d    = n_inputs;
              mask_d   = af_mask;
              sz_d     = sz_cfg;
              cnt_load = 1'b1;
              cnt_val  = CW'(n_inputs) - CW'(1);
            end else begin
              cfg_err = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (cnt_last) begin
            state_d  = S_MAC;
            input_d  = '0;
            cnt_load = 1'b1;
            cnt_val  = CW'(MAC_LAT - 1);
          end else begin
            input_d = input_q + NW'(1);
          end
        end
        S_MAC: begin
          if (cnt_last) begin
            if (cur_skip) begin
              state_d = S_WRITE;
            end else begin
              state_d  = S_ACT;
              cnt_load = 1'b1;
              cnt_val  = CW'(AF_LAT - 1);
            end
          end
        end
        S_ACT: begin
          if (cnt_last) begin
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          // Fan-in of the next layer is the size of the layer just finished.
          if (!last_neuron) begin
            state_d  = S_LOAD;
            neuron_d = neuron_q + NW'(1);
            cnt_load = 1'b1;
            cnt_val  = CW'(cur_fanin) - CW'(1);
          end else if (!last_layer) begin
            state_d  = S_LOAD;
            layer_d  = layer_q + LW'(1);
            neuron_d = '0;
            cnt_load = 1'b1;
            cnt_val  = CW'(cur_size) - CW'(1);
          end else begin
            state_d  = S_DONE;
            layer_d  = '0;
            neuron_d = '0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_d   = (state_d == S_LOAD) && !frz;
    cmp_d  = ((state_d == S_MAC) || (state_d == S_ACT)) && !frz;
    af_d   = (state_d == S_ACT) && !frz;
    wr_d   = (state_d == S_WRITE) && !frz;
    busy_d = state_d inside {S_LOAD, S_MAC, S_ACT, S_WRITE};
    done_d = (state_d == S_DONE);
    err_d  = cfg_err;
    osel_d = (layer_d != '0);
    bsel_d = (neuron_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q   <= 1'b0;
      cmp_q  <= 1'b0;
      af_q   <= 1'b0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      osel_q <= 1'b0;
      bsel_q <= 1'b0;
    end else begin
      ld_q   <= ld_d;
      cmp_q  <= cmp_d;
      af_q   <= af_d;
      wr_q   <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      osel_q <= osel_d;
      bsel_q <= bsel_d;
    end
  end

  assign weight_en      = ld_q;
  assign bias_en        = ld_q;
  assign compute_en     = cmp_q;
  assign af_en          = af_q;
  assign output_wr_en   = wr_q;
  assign output_shft_en = wr_q;
  assign output_sel     = osel_q;
  assign bias_sel       = bsel_q;
  assign layer_idx      = layer_q;
  assign neuron_idx     = neuron_q;
  assign input_idx      = input_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed self-checking bench for nn_layer_sequencer: timing of full runs,
// activation bypass, config errors, stall, abort, reset and start-while-busy.
module tb_nn_layer_sequencer;

  localparam int unsigned ML = 8;
  localparam int unsigned NW = 6;
  localparam int unsigned LW = 4;

  localparam int B_LD   = 26;
  localparam int B_CMP  = 24;
  localparam int B_AF   = 23;
  localparam int B_WR   = 22;
  localparam int B_BUSY = 18;
  localparam int B_ERR  = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, stall;
  logic [LW-1:0]    no_layers;
  logic [NW-1:0]    n_inputs;
  logic [ML*NW-1:0] layer_sizes;
  logic [ML-1:0]    af_mask;
  logic             weight_en, bias_en, compute_en, af_en;
  logic             output_wr_en, output_shft_en, output_sel, bias_sel;
  logic [LW-1:0]    layer_idx;
  logic [NW-1:0]    neuron_idx, input_idx;
  logic             busy, done, err;

  nn_layer_sequencer #(
    .MAX_LAYERS (ML),
    .NW         (NW),
    .LW         (LW),
    .MAC_LAT    (10),
    .AF_LAT     (30)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .stall          (stall),
    .no_layers      (no_layers),
    .n_inputs       (n_inputs),
    .layer_sizes    (layer_sizes),
    .af_mask        (af_mask),
    .weight_en      (weight_en),
    .bias_en        (bias_en),
    .compute_en     (compute_en),
    .af_en          (af_en),
    .output_wr_en   (output_wr_en),
    .output_shft_en (output_shft_en),
    .output_sel     (output_sel),
    .bias_sel       (bias_sel),
    .layer_idx      (layer_idx),
    .neuron_idx     (neuron_idx),
    .input_idx      (input_idx),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  logic [26:0] obs_now;
  assign obs_now = {weight_en, bias_en, compute_en, af_en, output_wr_en, output_shft_en,
                    output_sel, bias_sel, busy, done, err, layer_idx, neuron_idx, input_idx};

  logic [26:0] trace [0:511];
  int n_asserts = 0;
  int n_fail    = 0;
  int busy_cnt, ld_cnt, cmp_cnt, af_cnt, af_l1, wr_cnt, done_cnt, done_c;
  int err_cnt, osel_cnt, osel_first, strobe_cnt;
  int wr_c [4];

  function automatic logic [26:0] pk(input logic ld, cmp, af, wr, osel, bsel, bsy, dn, er,
                                     input logic [3:0] l, input logic [5:0] n, input logic [5:0] i);
    return {ld, ld, cmp, af, wr, wr, osel, bsel, bsy, dn, er, l, n, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller raises start at a negedge; cycle 1 is the first cycle after acceptance.
  task automatic run(input int budget, input int stall_at, input int stall_len,
                     input int abort_at, input int restart_at);
    busy_cnt = 0; ld_cnt = 0; cmp_cnt = 0; af_cnt = 0; af_l1 = 0; wr_cnt = 0;
    done_cnt = 0; done_c = -1; err_cnt = 0; osel_cnt = 0; osel_first = -1; strobe_cnt = 0;
    for (int k = 0; k < 4; k++) wr_c[k] = -1;
    for (int k = 0; k < 512; k++) trace[k] = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      abort = (c == abort_at);
      trace[c] = obs_now;
      if (busy) busy_cnt++;
      if (weight_en) ld_cnt++;
      if (compute_en) cmp_cnt++;
      if (af_en) af_cnt++;
      if (af_en && layer_idx == 4'd1) af_l1++;
      if (err) err_cnt++;
      if (weight_en || compute_en || af_en || output_wr_en) strobe_cnt++;
      if (output_sel) begin
        osel_cnt++;
        if (osel_first < 0) osel_first = c;
      end
      if (output_wr_en) begin
        if (wr_cnt < 4) wr_c[wr_cnt] = c;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  task automatic cfg_default();
    no_layers   = 4'd2;
    n_inputs    = 6'd2;
    layer_sizes = '0;
    layer_sizes[5:0]  = 6'd2;
    layer_sizes[11:6] = 6'd1;
    af_mask     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    cfg_default();
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs_now), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(obs_now), 32'd0);

    // Baseline two-layer run.
    start = 1'b1;
    run(300, 0, 0, 0, 0);
    check("run1_busy_len", busy_cnt, 129);
    check("run1_done_cycle", done_c, 130);
    check("run1_done_pulses", done_cnt, 1);
    check("run1_write_count", wr_cnt, 3);
    check("run1_write0", wr_c[0], 43);
    check("run1_write1", wr_c[1], 86);
    check("run1_write2", wr_c[2], 129);
    check("run1_osel_cycles", osel_cnt, 43);
    check("run1_osel_first", osel_first, 87);
    check("run1_load_cycles", ld_cnt, 6);
    check("run1_af_cycles", af_cnt, 90);
    check("run1_c1", 32'(trace[1]), 32'(pk(1,0,0,0,0,0,1,0,0,4'd0,6'd0,6'd0)));
    check("run1_c2", 32'(trace[2]), 32'(pk(1,0,0,0,0,0,1,0,0,4'd0,6'd0,6'd1)));
    check("run1_c3", 32'(trace[3]), 32'(pk(0,1,0,0,0,0,1,0,0,4'd0,6'd0,6'd0)));
    check("run1_c12", 32'(trace[12]), 32'(pk(0,1,0,0,0,0,1,0,0,4'd0,6'd0,6'd0)));
    check("run1_c13", 32'(trace[13]), 32'(pk(0,1,1,0,0,0,1,0,0,4'd0,6'd0,6'd0)));
    check("run1_c43", 32'(trace[43]), 32'(pk(0,0,0,1,0,0,1,0,0,4'd0,6'd0,6'd0)));
    check("run1_c44", 32'(trace[44]), 32'(pk(1,0,0,0,0,1,1,0,0,4'd0,6'd1,6'd0)));
    check("run1_c87", 32'(trace[87]), 32'(pk(1,0,0,0,1,0,1,0,0,4'd1,6'd0,6'd0)));
    check("run1_c130", 32'(trace[130]), 32'(pk(0,0,0,0,0,0,0,1,0,4'd0,6'd0,6'd0)));
    check("run1_c131", 32'(trace[131]), 32'd0);

    // Activation bypass on layer 1.
    af_mask = 8'b0000_0010;
    start = 1'b1;
    run(300, 0, 0, 0, 0);
    check("mask_busy_len", busy_cnt, 99);
    check("mask_done_cycle", done_c, 100);
    check("mask_write2", wr_c[2], 99);
    check("mask_af_layer1", af_l1, 0);
    check("mask_af_cycles", af_cnt, 60);
    af_mask = '0;

    // Illegal configurations: zero layers, too many layers, empty first layer.
    for (int t = 0; t < 3; t++) begin
      cfg_default();
      if (t == 0) no_layers = 4'd0;
      if (t == 1) no_layers = 4'd9;
      if (t == 2) layer_sizes[5:0] = 6'd0;
      start = 1'b1;
      run(6, 0, 0, 0, 0);
      check($sformatf("err%0d_flag_c1", t), 32'(trace[1][B_ERR]), 32'd1);
      check($sformatf("err%0d_pulses", t), err_cnt, 1);
      check($sformatf("err%0d_busy", t), busy_cnt, 0);
      check($sformatf("err%0d_strobes", t), strobe_cnt, 0);
    end
    cfg_default();

    // Stall for five cycles inside MAC of neuron 0.
    start = 1'b1;
    run(300, 5, 5, 0, 0);
    begin
      int lows;
      lows = 0;
      for (int k = 6; k <= 10; k++) if (trace[k][B_CMP] == 1'b0) lows++;
      check("stall_cmp_low_window", lows, 5);
    end
    check("stall_cmp_c5", 32'(trace[5][B_CMP]), 32'd1);
    check("stall_cmp_c11", 32'(trace[11][B_CMP]), 32'd1);
    check("stall_busy_len", busy_cnt, 134);
    check("stall_done_cycle", done_c, 135);
    check("stall_cmp_cycles", cmp_cnt, 120);
    check("stall_write0", wr_c[0], 48);

    // Abort at cycle 20, then a fresh run.
    start = 1'b1;
    run(40, 0, 0, 20, 0);
    check("abort_c20_busy", 32'(trace[20][B_BUSY]), 32'd1);
    check("abort_c21_all_zero", 32'(trace[21]), 32'd0);
    check("abort_busy_len", busy_cnt, 20);
    check("abort_no_done", done_cnt, 0);
    start = 1'b1;
    run(300, 0, 0, 0, 0);
    check("post_abort_busy_len", busy_cnt, 129);
    check("post_abort_done_cycle", done_c, 130);

    // Asynchronous reset in the middle of ACT.
    start = 1'b1;
    run(20, 0, 0, 0, 0);
    check("rst_in_act", 32'(trace[20][B_AF]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_zero", 32'(obs_now), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_after", 32'(obs_now), 32'd0);

    // Start while busy must not disturb timing.
    start = 1'b1;
    run(300, 0, 0, 0, 30);
    check("restart_busy_len", busy_cnt, 129);
    check("restart_done_cycle", done_c, 130);
    check("restart_write1", wr_c[1], 86);
    check("restart_done_pulses", done_cnt, 1);
    check("restart_ld_strobe", 32'(trace[44][B_LD]), 32'd1);
    check("restart_wr_strobe", 32'(trace[129][B_WR]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Parametrised master sequencer for the CORDIC-based NN inference datapath. It walks a configurable number of fully-connected layers and every neuron in each layer. For each neuron it drives the weight/bias load, CORDIC MAC, activation and output-write strobes. It adds per-layer activation bypass, a downstream stall, abort, and configuration error reporting.

## Interface
- MAX_LAYERS, 8: maximum supported layers
- NW, 6: width of neuron counts and indices
- LW, $clog2(MAX_LAYERS)+1: width of layer count/index
- MAC_LAT, 10: CORDIC MAC cycles per neuron (≥1)
- AF_LAT, 30: activation cycles per neuron (≥1)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  synchronous abort, any state
- stall  in  1  datapath not ready; freezes sequencing
- no_layers  in  LW  layers to run, legal 1..MAX_LAYERS
- n_inputs  in  NW  fan-in of layer 0, legal ≥1
- layer_sizes  in  MAX_LAYERS*NW  neurons in layer k at [k*NW +: NW], legal ≥1 for k<no_layers
- af_mask  in  MAX_LAYERS  bit k=1: skip activation for layer k
- weight_en, bias_en  out  1  parameter fetch strobes
- compute_en, af_en  out  1  MAC / activation enables
- output_wr_en, output_shft_en  out  1  neuron result write/shift
- output_sel  out  1  0: input source is external inputs; 1: previous-layer buffer
- bias_sel  out  1  0: first neuron of the layer; 1: otherwise
- layer_idx  out  LW;  neuron_idx, input_idx  out  NW  current position
- busy  out  1;  done, err  out  1  one-cycle pulses

## Operation
- All outputs are registered. On reset, all outputs are 0 and the FSM is in IDLE. Configuration inputs are captured at start acceptance and must not be re-read mid-run.
- States: IDLE → LOAD → MAC → ACT → WRITE → (LOAD | DONE) → IDLE.
- IDLE: on start=1 with abort=0, the config is checked.
  - Illegal config (no_layers==0 or >MAX_LAYERS, n_inputs==0, or any used layer size 0): pulse err for one cycle and stay in IDLE.
  - Legal config: go to LOAD with layer_idx=0, neuron_idx=0, input_idx=0.
- fan_in(L) = n_inputs for L=0, otherwise layer_sizes[L-1].
- LOAD: weight_en=bias_en=1 for fan_in(L) cycles; input_idx counts 0..fan_in(L)-1.
- MAC: compute_en=1 for MAC_LAT cycles.
- ACT: compute_en=af_en=1 for AF_LAT cycles. Skipped entirely (MAC → WRITE) when af_mask[L]=1.
- WRITE: output_wr_en=output_shft_en=1 for one cycle, then:
  - more neurons in the layer: neuron_idx+1 → LOAD;
  - last neuron, more layers: layer_idx+1, neuron_idx=0 → LOAD;
  - last neuron of the last layer → DONE.
- output_sel=(layer_idx!=0). bias_sel=(neuron_idx!=0). Both are valid throughout LOAD.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in LOAD, MAC, ACT and WRITE.
- stall=1 in LOAD, MAC, ACT or WRITE: FSM, counters and indices hold, and all strobes read 0 that cycle. The phase resumes at the same count when stall=0.
- abort=1: next cycle IDLE, all strobes and busy 0, no done. Abort beats start and stall.
- start while busy is ignored. Reset mid-run returns to IDLE immediately.

## Timing
- Start accepted at edge t → LOAD strobes are visible from cycle t+1.
- Neuron cost = fan_in(L) + MAC_LAT + (af_mask[L] ? 0 : AF_LAT) + 1 cycles.
- Busy length = sum over layers of size(L) × neuron cost(L), plus stall cycles. done asserts in the cycle after the final WRITE.
- Phase boundaries have no gap cycles: the last LOAD cycle is followed directly by the first MAC cycle.

## Structure
- Package nn_seq_pkg holds:
  - the state enum (IDLE, LOAD, MAC, ACT, WRITE, DONE);
  - default MAC_LAT/AF_LAT constants;
  - the size-slice helper function.
- Sub-module nn_phase_counter: loadable down-counter with hold (stall) and a last-count flag, instantiated once. It is shared across the LOAD, MAC and ACT phases and reloaded at each phase entry.

## Test plan
- n_inputs=2, no_layers=2, sizes {2,1}, af_mask=0, defaults → busy 129 cycles.
  - Exactly 3 WRITE pulses, at busy cycles 43, 86 and 129; done at cycle 130.
  - output_sel=1 only during layer 1.
- Same config with af_mask[1]=1 → busy 99 cycles; af_en never high in layer 1.
- no_layers=0 or layer_sizes[0]=0 with start → err pulse; busy stays 0; no strobes.
- stall high for 5 cycles in the middle of MAC of neuron 0 → compute_en low for those 5 cycles; total busy extends by exactly 5.
- abort at cycle 20 of the first run → next cycle all outputs 0 and no done. A fresh start then completes normally.
- rst_n low mid-ACT → outputs 0 asynchronously; start while busy has no effect on timing.
